urv_writeback: RTL and testbench
================================

// Module: urv_writeback
// PURPOSE
//  Writeback stage of the uRV pipeline; sits between execute/memory and urv_regfile.
//  Registers ALU results and aligns/sign-extends load data returned by the data memory.
//  Drives the regfile write port (w_rd_i / w_rd_value_i / w_rd_store_i) and the bypass port.
//  Stalls the pipeline while a load is outstanding; bounded by a timeout counter.
// PARAMETERS
//  LOAD_TIMEOUT  255  max WAIT cycles before abandoning a load (1..65535)
//  WITH_TIMEOUT  1    1 = timeout enabled; 0 = wait forever for dm_load_done_i
// PORTS
//  clk_i                in   1   clock, all logic on rising edge
//  rst_i                in   1   synchronous reset, active-low
//  x_valid_i            in   1   execute stage presents an instruction this cycle
//  x_rd_i               in   5   destination register
//  x_rd_value_i         in   32  ALU/CSR result (non-load)
//  x_rd_write_i         in   1   instruction writes rd
//  x_load_i             in   1   instruction is a load
//  x_fun3_i             in   3   load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//  x_addr_lsb_i         in   2   load address bits [1:0]
//  dm_load_done_i       in   1   memory returns load data this cycle
//  dm_data_l_i          in   32  raw load word from memory
//  w_stall_o            out  1   hold upstream; x_valid_i ignored while high
//  rf_rd_o              out  5   to regfile w_rd_i
//  rf_rd_value_o        out  32  to regfile w_rd_value_i
//  rf_rd_write_o        out  1   to regfile w_rd_store_i (one-cycle pulse)
//  w_bypass_rd_write_o  out  1   bypass valid (to w_bypass_rd_write_i)
//  w_bypass_rd_value_o  out  32  bypass value (to w_bypass_rd_value_i)
//  dm_error_o           out  1   sticky: a load timed out
// BEHAVIOUR
//  - Reset (rst_i=0 at edge): state IDLE, timeout counter 0, all outputs 0; overrides
//    everything incl. an outstanding load (load dropped, no write).
//  - States: IDLE, WAIT. w_stall_o = (state==WAIT), purely from state register.
//  - IDLE, x_valid_i=1, x_load_i=0: next cycle rf_rd_o=x_rd_i, rf_rd_value_o=x_rd_value_i,
//    rf_rd_write_o = x_rd_write_i && x_rd_i!=0; latency 1. Otherwise rf_rd_write_o=0.
//  - IDLE, x_valid_i=1, x_load_i=1: latch rd, fun3, addr_lsb, (rd!=0) -> WAIT, counter=0.
//    dm_load_done_i is ignored in IDLE (earliest response is first WAIT cycle).
//  - WAIT: counter +1 per cycle. On dm_load_done_i: aligned data registered, -> IDLE;
//    rf_rd_write_o pulses the following cycle (if rd!=0). Back-to-back accept is legal
//    on that IDLE cycle; writes never collide (max one write per cycle).
//  - Timeout (WITH_TIMEOUT=1): counter==LOAD_TIMEOUT-1 and no done -> IDLE, no write,
//    dm_error_o<=1 (sticky until reset). done and timeout same cycle: done wins, no error.
//  - Alignment: byte = word[8*lsb+7 -: 8]; half = lsb[1] ? word[31:16] : word[15:0];
//    LB/LH sign-extend, LBU/LHU zero-extend, LW and undefined fun3 pass word. lsb[0]
//    ignored for halves (no misalignment trap here).
//  - Bypass: w_bypass_rd_write_o == rf_rd_write_o, w_bypass_rd_value_o == rf_rd_value_o
//    every cycle (same registered source).
//  - rd==x0: instruction fully processed (loads still stall) but write/bypass stay 0.
//  - x_valid_i while w_stall_o=1: ignored; upstream must hold it.
// TESTING
//  - ADD x5=0x1234_5678 valid 1 cycle -> next cycle rf_rd_o=5, value 0x12345678, write=1,
//    bypass identical; following cycle write=0.
//  - LB x7, lsb=3, done after 2 WAIT cycles, data 0x80FF_0000 -> stall 2 cycles, then
//    write x7=0xFFFF_FF80; same with LBU -> 0x0000_0080; LHU lsb=2 -> 0x0000_80FF.
//  - Load to x0, data 0xDEADBEEF -> stall until done, rf_rd_write_o never asserts.
//  - LOAD_TIMEOUT=4, no done -> stall exactly 4 cycles, no write, dm_error_o=1 held;
//    repeat with done on 4th WAIT cycle -> write occurs, dm_error_o stays 0.
//  - Reset asserted in WAIT, done arrives next cycle -> no write, outputs 0, state IDLE.
//  - Load done then ADD accepted immediately -> two consecutive write pulses, correct
//    rd/value each, no cycle dropped.

Source files
------------

// File: rtl/urv_writeback.sv
// uRV writeback stage: registers ALU results, aligns/sign-extends load data,
// drives the regfile write port and bypass, and stalls while a load is pending.
module urv_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 255,
  parameter bit          WITH_TIMEOUT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun3_i,
  input  logic [1:0]  x_addr_lsb_i,
  input  logic        dm_load_done_i,
  input  logic [31:0] dm_data_l_i,
  output logic        w_stall_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_bypass_rd_write_o,
  output logic [31:0] w_bypass_rd_value_o,
  output logic        dm_error_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         ld_rd_q, ld_rd_d;
  logic [2:0]         ld_fun3_q, ld_fun3_d;
  logic [1:0]         ld_lsb_q, ld_lsb_d;
  logic               ld_wr_q, ld_wr_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        val_q, val_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;
  logic [31:0]        load_val;

  // Select and extend the addressed byte/half of the returned word
  always_comb begin
    load_byte = dm_data_l_i[7:0];
    load_half = ld_lsb_q[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    load_val  = dm_data_l_i;
    unique case (ld_lsb_q)
      2'd0:    load_byte = dm_data_l_i[7:0];
      2'd1:    load_byte = dm_data_l_i[15:8];
      2'd2:    load_byte = dm_data_l_i[23:16];
      default: load_byte = dm_data_l_i[31:24];
    endcase
    unique case (ld_fun3_q)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'h000000, load_byte};
      3'b101:  load_val = {16'h0000, load_half};
      default: load_val = dm_data_l_i;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_fun3_d = ld_fun3_q;
    ld_lsb_d  = ld_lsb_q;
    ld_wr_d   = ld_wr_q;
    rd_d      = rd_q;
    val_d     = val_q;
    wr_d      = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (x_valid_i) begin
          if (x_load_i) begin
            ld_rd_d   = x_rd_i;
            ld_fun3_d = x_fun3_i;
            ld_lsb_d  = x_addr_lsb_i;
            ld_wr_d   = (x_rd_i != 5'd0);
            cnt_d     = '0;
            state_d   = S_WAIT;
          end else begin
            rd_d  = x_rd_i;
            val_d = x_rd_value_i;
            wr_d  = x_rd_write_i && (x_rd_i != 5'd0);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the final allowed cycle still completes the load
        if (dm_load_done_i) begin
          rd_d    = ld_rd_q;
          val_d   = load_val;
          wr_d    = ld_wr_q;
          state_d = S_IDLE;
        end else if (WITH_TIMEOUT && (cnt_q == CNT_W'(LOAD_TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_fun3_q <= '0;
      ld_lsb_q  <= '0;
      ld_wr_q   <= 1'b0;
      rd_q      <= '0;
      val_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_fun3_q <= ld_fun3_d;
      ld_lsb_q  <= ld_lsb_d;
      ld_wr_q   <= ld_wr_d;
      rd_q      <= rd_d;
      val_q     <= val_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
    end
  end

  assign w_stall_o           = (state_q == S_WAIT);
  assign rf_rd_o             = rd_q;
  assign rf_rd_value_o       = val_q;
  assign rf_rd_write_o       = wr_q;
  assign w_bypass_rd_write_o = wr_q;
  assign w_bypass_rd_value_o = val_q;
  assign dm_error_o          = err_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Bench for urv_writeback: vector table of ALU/load instructions with a
// cycle-stamped write scoreboard, plus reset-during-load and timeout sequences.
module tb_urv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_valid_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i;
  logic        x_rd_write_i;
  logic        x_load_i;
  logic [2:0]  x_fun3_i;
  logic [1:0]  x_addr_lsb_i;
  logic        dm_load_done_i;
  logic [31:0] dm_data_l_i;
  logic        w_stall_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic        w_bypass_rd_write_o;
  logic [31:0] w_bypass_rd_value_o;
  logic        dm_error_o;

  urv_writeback #(.LOAD_TIMEOUT(4), .WITH_TIMEOUT(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .x_valid_i(x_valid_i), .x_rd_i(x_rd_i), .x_rd_value_i(x_rd_value_i),
    .x_rd_write_i(x_rd_write_i), .x_load_i(x_load_i), .x_fun3_i(x_fun3_i),
    .x_addr_lsb_i(x_addr_lsb_i), .dm_load_done_i(dm_load_done_i),
    .dm_data_l_i(dm_data_l_i), .w_stall_o(w_stall_o), .rf_rd_o(rf_rd_o),
    .rf_rd_value_o(rf_rd_value_o), .rf_rd_write_o(rf_rd_write_o),
    .w_bypass_rd_write_o(w_bypass_rd_write_o),
    .w_bypass_rd_value_o(w_bypass_rd_value_o), .dm_error_o(dm_error_o)
  );

  always #5 clk_i = ~clk_i;

  // k = WAIT cycles up to and including the done cycle; 0 = never done
  typedef struct {
    bit          ld;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          wr;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    int          k;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else
      pass_cnt++;
  endtask

  task automatic push(input int c, input logic [4:0] rd, input logic [31:0] val);
    exp_t e;
    e.cyc = c; e.rd = rd; e.val = val;
    sb.push_back(e);
  endtask

  // Advance one clock and check the write port against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_write_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("rf_write", 32'(rf_rd_write_o), 32'd1);
      chk("rf_rd", 32'(rf_rd_o), 32'(e.rd));
      chk("rf_value", rf_rd_value_o, e.val);
      chk("byp_write", 32'(w_bypass_rd_write_o), 32'd1);
      chk("byp_value", w_bypass_rd_value_o, e.val);
    end else if (rf_rd_write_o || w_bypass_rd_write_o) begin
      chk("spurious_write", {30'd0, w_bypass_rd_write_o, rf_rd_write_o}, 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    x_valid_i    = 1'b1;
    x_load_i     = v.ld;
    x_rd_i       = v.rd;
    x_rd_value_i = v.val;
    x_rd_write_i = v.wr;
    x_fun3_i     = v.f3;
    x_addr_lsb_i = v.lsb;
    if (!v.ld) begin
      if (v.wr && v.rd != 5'd0) push(cyc + 1, v.rd, v.val);
      tick();
      x_valid_i = 1'b0;
      chk("alu_stall", 32'(w_stall_o), 32'd0);
    end else begin
      // done in IDLE must be ignored; junk instruction held during WAIT
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'hA5A5_A5A5;
      tick();
      dm_load_done_i = 1'b0;
      x_load_i       = 1'b0;
      x_rd_i         = 5'd9;
      x_rd_value_i   = 32'hBAD0_BAD0;
      x_rd_write_i   = 1'b1;
      if (v.k == 0) begin
        n = w_stall_o ? 1 : 0;
        while (w_stall_o && n < 10) begin
          tick();
          if (w_stall_o) n++;
        end
        x_valid_i = 1'b0;
        chk("timeout_stall_cycles", 32'(n), 32'd4);
        err_exp = 1'b1;
      end else begin
        for (int i = 1; i <= v.k; i++) begin
          chk("wait_stall", 32'(w_stall_o), 32'd1);
          if (i == v.k) begin
            dm_load_done_i = 1'b1;
            dm_data_l_i    = v.data;
            x_valid_i      = 1'b0;
            if (v.rd != 5'd0) push(cyc + 1, v.rd, v.exp);
          end
          tick();
        end
        dm_load_done_i = 1'b0;
        chk("load_end_stall", 32'(w_stall_o), 32'd0);
      end
    end
    chk("dm_error", 32'(dm_error_o), 32'(err_exp));
  endtask

  function automatic vec_t mk(bit ld, logic [4:0] rd, logic [31:0] val, bit wr,
                              logic [2:0] f3, logic [1:0] lsb, int k,
                              logic [31:0] data, logic [31:0] exp);
    vec_t v;
    v.ld = ld; v.rd = rd; v.val = val; v.wr = wr; v.f3 = f3; v.lsb = lsb;
    v.k = k; v.data = data; v.exp = exp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ld rd     val           wr f3      lsb k  data          expected
    vecs.push_back(mk(0, 5'd5,  32'h1234_5678, 1, 3'b000, 2'd0, 0, 32'h0,        32'h1234_5678));
    vecs.push_back(mk(1, 5'd7,  32'h0,         0, 3'b000, 2'd3, 2, 32'h80FF_0000, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 5'd7,  32'h0,         0, 3'b100, 2'd3, 2, 32'h80FF_0000, 32'h0000_0080));
    vecs.push_back(mk(1, 5'd8,  32'h0,         0, 3'b101, 2'd2, 1, 32'h80FF_0000, 32'h0000_80FF));
    vecs.push_back(mk(0, 5'd6,  32'hCAFE_F00D, 1, 3'b000, 2'd0, 0, 32'h0,        32'hCAFE_F00D));
    vecs.push_back(mk(1, 5'd9,  32'h0,         0, 3'b001, 2'd3, 1, 32'h80FF_0000, 32'hFFFF_80FF));
    vecs.push_back(mk(1, 5'd10, 32'h0,         0, 3'b000, 2'd0, 3, 32'h1234_567F, 32'h0000_007F));
    vecs.push_back(mk(1, 5'd11, 32'h0,         0, 3'b000, 2'd1, 1, 32'h0000_8100, 32'hFFFF_FF81));
    vecs.push_back(mk(1, 5'd12, 32'h0,         0, 3'b010, 2'd0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(mk(1, 5'd13, 32'h0,         0, 3'b011, 2'd2, 1, 32'h1357_9BDF, 32'h1357_9BDF));
    vecs.push_back(mk(1, 5'd14, 32'h0,         0, 3'b101, 2'd0, 2, 32'h0000_F00D, 32'h0000_F00D));
    vecs.push_back(mk(1, 5'd15, 32'h0,         0, 3'b001, 2'd1, 1, 32'h0000_7FFF, 32'h0000_7FFF));
    vecs.push_back(mk(1, 5'd0,  32'h0,         0, 3'b010, 2'd0, 2, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h5555_5555, 1, 3'b000, 2'd0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 5'd3,  32'h3333_3333, 0, 3'b000, 2'd0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 5'd31, 32'hFFFF_FFFF, 1, 3'b000, 2'd0, 0, 32'h0,        32'hFFFF_FFFF));
    vecs.push_back(mk(1, 5'd4,  32'h0,         0, 3'b010, 2'd0, 4, 32'h0BAD_F00D, 32'h0BAD_F00D));
    vecs.push_back(mk(1, 5'd4,  32'h0,         0, 3'b010, 2'd0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 5'd2,  32'h0000_0001, 1, 3'b000, 2'd0, 0, 32'h0,        32'h0000_0001));

    rst_i = 1'b0; x_valid_i = 1'b0; x_rd_i = '0; x_rd_value_i = '0; x_rd_write_i = 1'b0;
    x_load_i = 1'b0; x_fun3_i = '0; x_addr_lsb_i = '0; dm_load_done_i = 1'b0; dm_data_l_i = '0;
    tick();
    tick();
    chk("rst_stall", 32'(w_stall_o), 32'd0);
    chk("rst_rd", 32'(rf_rd_o), 32'd0);
    chk("rst_value", rf_rd_value_o, 32'd0);
    chk("rst_write", 32'(rf_rd_write_o), 32'd0);
    chk("rst_byp", {31'd0, w_bypass_rd_write_o} | w_bypass_rd_value_o, 32'd0);
    chk("rst_err", 32'(dm_error_o), 32'd0);
    rst_i = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in WAIT drops the load; a late done must not write
    x_valid_i = 1'b1; x_load_i = 1'b1; x_rd_i = 5'd20; x_fun3_i = 3'b010; x_addr_lsb_i = 2'd0;
    tick();
    x_valid_i = 1'b0; x_load_i = 1'b0;
    chk("rstwait_stall", 32'(w_stall_o), 32'd1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("rstwait_stall_clr", 32'(w_stall_o), 32'd0);
    chk("rstwait_rd", 32'(rf_rd_o), 32'd0);
    chk("rstwait_value", rf_rd_value_o, 32'd0);
    chk("rstwait_err_clr", 32'(dm_error_o), 32'd0);
    err_exp = 1'b0;
    dm_load_done_i = 1'b1; dm_data_l_i = 32'h7777_7777;
    tick();
    dm_load_done_i = 1'b0;
    chk("rstwait_after_done_stall", 32'(w_stall_o), 32'd0);
    chk("rstwait_after_done_wr", 32'(rf_rd_write_o), 32'd0);
    tick();
    run_vec(mk(0, 5'd21, 32'hA1B2_C3D4, 1, 3'b000, 2'd0, 0, 32'h0, 32'hA1B2_C3D4));

    tick();
    tick();
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
